bidir_cfg_loader: RTL and testbench

BIDIR_CFG_LOADER -- requirements
Module: bidir_cfg_loader

---
 rtl/routing_pkg.sv | 17 +
 rtl/cfg_shift_reg.sv | 47 ++++
 rtl/bidir_cfg_loader.sv | 111 +++++++++++
 tb/tb_bidir_cfg_loader.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/routing_pkg.sv
// Shared definitions for the routing block and its configuration loader.
//   CFG_W_DFLT : default width of the routing-block configuration word
//   TRACKS     : number of routing tracks in the routing block
//   ld_state_e : loader state encoding
package routing_pkg;

  localparam int CFG_W_DFLT = 36;
  localparam int TRACKS     = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2,
    COMMIT = 2'd3
  } ld_state_e;

endpackage

// File: rtl/cfg_shift_reg.sv
// Serial-to-parallel shift register with beat counter and running parity.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : clear register, counter and parity at the start of a load
//   shift_en   : accept din as the next (lower) bit of the word
//   din        : serial data bit, MSB first
//   sreg       : word assembled so far
//   par        : XOR of every bit shifted in since the last clear
//   last       : the next shifted bit completes the word
module cfg_shift_reg
  import routing_pkg::*;
#(
  parameter int CFG_W = CFG_W_DFLT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             shift_en,
  input  logic             din,
  output logic [CFG_W-1:0] sreg,
  output logic             par,
  output logic             last
);

  localparam int CNT_W = $clog2(CFG_W + 1);

  // Counts up to CFG_W at most: the loader stops shifting once the word is full.
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg <= '0;
      cnt  <= '0;
      par  <= 1'b0;
    end else if (clr) begin
      sreg <= '0;
      cnt  <= '0;
      par  <= 1'b0;
    end else if (shift_en) begin
      sreg <= {sreg[CFG_W-2:0], din};
      cnt  <= cnt + 1'b1;
      par  <= par ^ din;
    end
  end

  assign last = (cnt == CNT_W'(CFG_W - 1));

endmodule

// File: rtl/bidir_cfg_loader.sv
// Loads a routing-block configuration word from a serial bitstream, checks an
// even-parity trailer bit and commits the word atomically to cfg_out.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : begin a load (only honoured while idle)
//   abort      : cancel a load in progress
//   din        : serial data, MSB first, followed by one parity bit
//   din_valid  : din carries a bit this cycle
//   din_ready  : loader accepts a bit this cycle
//   cfg_out    : committed configuration word
//   cfg_update : one-cycle pulse coincident with a new cfg_out value
//   busy       : loader is not idle
//   err        : sticky parity-error flag, cleared by the next start
module bidir_cfg_loader
  import routing_pkg::*;
#(
  parameter int CFG_W = CFG_W_DFLT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic [CFG_W-1:0] cfg_out,
  output logic             cfg_update,
  output logic             busy,
  output logic             err
);

  ld_state_e        state;
  ld_state_e        state_nxt;
  logic             clr;
  logic             shift_en;
  logic             par_fail;
  logic             par;
  logic             last;
  logic [CFG_W-1:0] sreg;

  cfg_shift_reg #(.CFG_W(CFG_W)) u_sreg (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .shift_en (shift_en),
    .din      (din),
    .sreg     (sreg),
    .par      (par),
    .last     (last)
  );

  // abort takes priority over a beat arriving in the same cycle, so a
  // cancelled beat never reaches the shift register or the parity check.
  always_comb begin
    state_nxt = state;
    din_ready = 1'b0;
    clr       = 1'b0;
    shift_en  = 1'b0;
    par_fail  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = SHIFT;
          clr       = 1'b1;
        end
      end
      SHIFT: begin
        din_ready = 1'b1;
        if (abort) begin
          state_nxt = IDLE;
        end else if (din_valid) begin
          shift_en = 1'b1;
          if (last) state_nxt = PARITY;
        end
      end
      PARITY: begin
        din_ready = 1'b1;
        if (abort) begin
          state_nxt = IDLE;
        end else if (din_valid) begin
          par_fail  = par ^ din;
          state_nxt = (par ^ din) ? IDLE : COMMIT;
        end
      end
      COMMIT: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cfg_out    <= '0;
      cfg_update <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_nxt;
      cfg_update <= (state == COMMIT);
      // cfg_out only moves here, so the fabric never sees a partial word.
      if (state == COMMIT) cfg_out <= sreg;
      if (clr)           err <= 1'b0;
      else if (par_fail) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bidir_cfg_loader.sv
module tb_bidir_cfg_loader;

  localparam int W = 36;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic         din = 1'b0;
  logic         din_valid = 1'b0;
  logic         din_ready;
  logic [W-1:0] cfg_out;
  logic         cfg_update;
  logic         busy;
  logic         err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bidir_cfg_loader #(.CFG_W(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .cfg_out    (cfg_out),
    .cfg_update (cfg_update),
    .busy       (busy),
    .err        (err)
  );

  // Reference model: a load is a list of received bits; once W data bits and
  // one parity bit have arrived, an even total count of ones commits the word
  // one edge later, otherwise the error flag is raised.
  bit           m_loading = 1'b0;
  bit           m_pending = 1'b0;
  bit           q[$];
  logic [W-1:0] m_cfg = '0;
  bit           m_upd = 1'b0;
  bit           m_err = 1'b0;

  function automatic logic [W-1:0] word_of(input bit b[$]);
    logic [W-1:0] w;
    w = '0;
    foreach (b[i]) w[W-1-i] = b[i];
    return w;
  endfunction

  function automatic int ones(input bit b[$]);
    int n;
    n = 0;
    foreach (b[i]) n += int'(b[i]);
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_loading = 1'b0;
      m_pending = 1'b0;
      q.delete();
      m_cfg = '0;
      m_upd = 1'b0;
      m_err = 1'b0;
    end else begin
      m_upd = 1'b0;
      if (m_pending) begin
        m_cfg = word_of(q);
        m_upd = 1'b1;
        m_pending = 1'b0;
      end else if (!m_loading) begin
        if (start) begin
          m_loading = 1'b1;
          q.delete();
          m_err = 1'b0;
        end
      end else if (abort) begin
        m_loading = 1'b0;
      end else if (din_valid) begin
        if (q.size() < W) begin
          q.push_back(din);
        end else begin
          m_loading = 1'b0;
          if (((ones(q) + int'(din)) % 2) == 0) m_pending = 1'b1;
          else m_err = 1'b1;
        end
      end
    end
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      check("cfg_out", cfg_out, m_cfg);
      check1("cfg_update", cfg_update, m_upd);
      check1("err", err, m_err);
      check1("busy", busy, m_loading || m_pending);
      check1("din_ready", din_ready, m_loading);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one load; returns 1 ns after the edge that takes the parity beat
  // (or the edge that takes the aborting beat).
  task automatic load(input logic [W-1:0] w, input bit p, input bit gap,
                      input int abort_at, input bit hold_start);
    start = 1'b1;
    tick();
    start = hold_start;
    for (int k = 0; k <= W; k++) begin
      if (gap) begin
        din_valid = 1'b0;
        din = 1'($urandom);
        tick();
      end
      din_valid = 1'b1;
      if (k < W) din = w[W-1-k];
      else din = p;
      abort = (k + 1 == abort_at);
      tick();
      if (abort) begin
        abort = 1'b0;
        din_valid = 1'b0;
        start = 1'b0;
        return;
      end
    end
    din_valid = 1'b0;
    start = 1'b0;
  endtask

  initial begin
    #3;
    check("rst cfg_out", cfg_out, '0);
    check1("rst busy", busy, 1'b0);
    check1("rst din_ready", din_ready, 1'b0);
    check1("rst err", err, 1'b0);
    check1("rst cfg_update", cfg_update, 1'b0);
    #9 rst_n = 1'b1;
    tick();

    // Good parity, back-to-back beats.
    load(36'h000000080, 1'b1, 1'b0, -1, 1'b0);
    check("commit early", cfg_out, 36'h0);
    check1("commit early upd", cfg_update, 1'b0);
    check1("commit busy", busy, 1'b1);
    tick();
    check("commit cfg_out", cfg_out, 36'h000000080);
    check1("commit upd", cfg_update, 1'b1);
    check1("commit err", err, 1'b0);
    tick();
    check1("upd one cycle", cfg_update, 1'b0);
    check1("idle after commit", busy, 1'b0);

    // Bad parity.
    load(36'h000000080, 1'b0, 1'b0, -1, 1'b0);
    check1("perr err", err, 1'b1);
    check1("perr idle", busy, 1'b0);
    check("perr cfg kept", cfg_out, 36'h000000080);
    tick();
    check1("perr no upd", cfg_update, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check1("start clears err", err, 1'b0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check1("abort idle", busy, 1'b0);

    // Gapped beats.
    load(36'h000000040, 1'b1, 1'b1, -1, 1'b0);
    check("gap not early", cfg_out, 36'h000000080);
    tick();
    check("gap cfg_out", cfg_out, 36'h000000040);
    check1("gap upd", cfg_update, 1'b1);
    tick();

    // Abort on the 20th beat, then a full load with start held high throughout.
    load(36'h123456789, 1'b1, 1'b0, 20, 1'b0);
    check1("abort20 busy", busy, 1'b0);
    check("abort20 cfg", cfg_out, 36'h000000040);
    load(36'hFFFFFFFFF, 1'b0, 1'b0, -1, 1'b1);
    tick();
    check("ones cfg_out", cfg_out, 36'hFFFFFFFFF);
    check1("ones upd", cfg_update, 1'b1);
    check1("ones err", err, 1'b0);
    tick();

    // Short reset pulse in the middle of a load.
    start = 1'b1;
    tick();
    for (int i = 0; i < 10; i++) begin
      din_valid = 1'b1;
      din = 1'b1;
      tick();
    end
    start = 1'b0;
    din_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("mid rst cfg_out", cfg_out, '0);
    check1("mid rst busy", busy, 1'b0);
    check1("mid rst ready", din_ready, 1'b0);
    check1("mid rst err", err, 1'b0);
    check1("mid rst upd", cfg_update, 1'b0);
    #1 rst_n = 1'b1;
    tick();
    check1("post rst idle", busy, 1'b0);

    // Random traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      start = ($urandom_range(0, 2) == 0);
      abort = ($urandom_range(0, 79) == 0);
      din_valid = ($urandom_range(0, 3) != 0);
      din = 1'($urandom);
      if ($urandom_range(0, 799) == 0) begin
        #1 rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
      tick();
    end

    start = 1'b0;
    abort = 1'b0;
    din_valid = 1'b0;
    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
